booth_control_unit: RTL and testbench

//  Sequencing FSM for the signed radix-2 Booth multiplier datapath (A/Q/Q-1/M registers).

---
 rtl/booth_control_unit.sv | 136 +++++++++++++
 tb/tb_booth_control_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_control_unit.sv
// rtl/booth_control_unit.sv - sequencing FSM for a signed radix-2 Booth multiplier
//
// Converts a debounced push-button level into exactly one multiply on the
// A/Q/Q[-1]/M datapath: one load cycle, N_BITS evaluate/shift pairs, then a
// one-cycle result latch. The datapath and product register live outside this
// block. busy, done and step_count are intended for status LEDs.
//
// Parameters
//   N_BITS        operand width, which is also the number of Booth iterations
//   CNT_W         step counter width; must be able to hold N_BITS
//
// Ports
//   CLK100MHZ     in   system clock; all logic runs on the rising edge
//   reset         in   synchronous, active-high
//   start         in   debounced button level; a rising edge requests a multiply
//   q_lsb         in   Q[0] from the datapath
//   q_minus1      in   Q[-1] from the datapath
//   load_regs     out  A<=0, Q<=multiplier, M<=multiplicand, Q[-1]<=0
//   add_m         out  A<=A+M (wraps at N_BITS)
//   sub_m         out  A<=A-M (wraps at N_BITS)
//   shift_ars     out  arithmetic shift right of {A,Q,Q[-1]}
//   latch_result  out  product register <= {A,Q}
//   busy          out  high from LOAD through FINISH inclusive
//   done          out  one-cycle pulse in FINISH
//   step_count    out  Booth iterations still to run

module booth_control_unit #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 4
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             start,
    input  logic             q_lsb,
    input  logic             q_minus1,
    output logic             load_regs,
    output logic             add_m,
    output logic             sub_m,
    output logic             shift_ars,
    output logic             latch_result,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EVAL   = 3'd2,
        SHIFT  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STEP_INIT = CNT_W'(N_BITS);
    localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

    state_t state;
    state_t state_nxt;
    logic   start_d;
    logic   req;
    logic   last_step;

    // A rising edge of the button level is the only thing that starts a
    // multiply. start_d is forced high in reset so a button that is already
    // held when reset releases does not fire.
    assign req       = start & ~start_d;
    assign last_step = (step_count == STEP_ONE);

    // State register, edge-detect history and iteration counter.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state      <= IDLE;
            start_d    <= 1'b1;
            step_count <= '0;
        end else begin
            state   <= state_nxt;
            start_d <= start;
            case (state)
                LOAD:    step_count <= STEP_INIT;
                SHIFT:   step_count <= step_count - STEP_ONE;
                default: step_count <= step_count;
            endcase
        end
    end

    // Next-state logic. A request that arrives while a multiply is running
    // is dropped, not remembered; the user must release and press again.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = req ? LOAD : IDLE;
            LOAD:    state_nxt = EVAL;
            EVAL:    state_nxt = SHIFT;
            SHIFT:   state_nxt = last_step ? FINISH : EVAL;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. Each state drives at most one datapath control, so the
    // controls are mutually exclusive by construction. The add/sub choice is
    // the Booth recoding of the current {Q[0], Q[-1]} pair.
    always_comb begin
        load_regs    = 1'b0;
        add_m        = 1'b0;
        sub_m        = 1'b0;
        shift_ars    = 1'b0;
        latch_result = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            LOAD: begin
                load_regs = 1'b1;
                busy      = 1'b1;
            end
            EVAL: begin
                busy  = 1'b1;
                sub_m = q_lsb & ~q_minus1;
                add_m = ~q_lsb & q_minus1;
            end
            SHIFT: begin
                busy      = 1'b1;
                shift_ars = 1'b1;
            end
            FINISH: begin
                busy         = 1'b1;
                latch_result = 1'b1;
                done         = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_control_unit.sv
// tb/tb_booth_control_unit.sv - self-checking bench for booth_control_unit

module tb_booth_control_unit;

    localparam int N = 8;

    logic       CLK100MHZ = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b1;
    logic       q_lsb;
    logic       q_minus1;
    logic       load_regs;
    logic       add_m;
    logic       sub_m;
    logic       shift_ars;
    logic       latch_result;
    logic       busy;
    logic       done;
    logic [3:0] step_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural Booth datapath driven by the controls under test.
    logic [N-1:0]   op_a = '0;
    logic [N-1:0]   op_b = '0;
    logic [N-1:0]   dp_a = '0;
    logic [N-1:0]   dp_q = '0;
    logic           dp_qm1 = 1'b0;
    logic [N-1:0]   dp_m = '0;
    logic [2*N-1:0] product = '0;

    // Expected Booth operation per iteration: 0 none, 1 add, 2 sub.
    int bops[1:N];

    always #5 CLK100MHZ = ~CLK100MHZ;

    booth_control_unit #(.N_BITS(8), .CNT_W(4)) dut (
        .CLK100MHZ    (CLK100MHZ),
        .reset        (reset),
        .start        (start),
        .q_lsb        (q_lsb),
        .q_minus1     (q_minus1),
        .load_regs    (load_regs),
        .add_m        (add_m),
        .sub_m        (sub_m),
        .shift_ars    (shift_ars),
        .latch_result (latch_result),
        .busy         (busy),
        .done         (done),
        .step_count   (step_count)
    );

    assign q_lsb    = dp_q[0];
    assign q_minus1 = dp_qm1;

    always_ff @(posedge CLK100MHZ) begin
        if (load_regs) begin
            dp_a   <= '0;
            dp_q   <= op_b;
            dp_qm1 <= 1'b0;
            dp_m   <= op_a;
        end else if (add_m) begin
            dp_a <= dp_a + dp_m;
        end else if (sub_m) begin
            dp_a <= dp_a - dp_m;
        end else if (shift_ars) begin
            {dp_a, dp_q, dp_qm1} <= {dp_a[N-1], dp_a, dp_q};
        end
        if (latch_result) begin
            product <= {dp_a, dp_q};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Booth recoding of the multiplier: iteration i looks at {b[i-1], b[i-2]},
    // with an implied 0 below bit 0.
    task automatic plan_ops(input logic [N-1:0] b);
        for (int i = 1; i <= N; i++) begin
            logic hi;
            logic lo;
            hi = b[i-1];
            lo = (i == 1) ? 1'b0 : b[i-2];
            if (hi && !lo)      bops[i] = 2;
            else if (!hi && lo) bops[i] = 1;
            else                bops[i] = 0;
        end
    endtask

    // Expected {load,add,sub,shift,latch,busy,done,step[3:0]} in cycle c
    // after the request edge (c=1 is the load cycle).
    function automatic logic [10:0] exp_vec(input int c);
        logic [10:0] v;
        int          it;
        v = '0;
        if (c == 1) begin
            v[10] = 1'b1;
            v[5]  = 1'b1;
        end else if (c >= 2 && c <= 2 * N + 1) begin
            it    = c / 2;
            v[5]  = 1'b1;
            v[3:0] = 4'(N - it + 1);
            if (c % 2 == 0) begin
                v[9] = (bops[it] == 1);
                v[8] = (bops[it] == 2);
            end else begin
                v[7] = 1'b1;
            end
        end else if (c == 2 * N + 2) begin
            v[6] = 1'b1;
            v[5] = 1'b1;
            v[4] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [10:0] obs_vec();
        return {load_regs, add_m, sub_m, shift_ars, latch_result, busy, done, step_count};
    endfunction

    // Called at a negedge with start low for at least one prior edge.
    // hold keeps start high; pulses adds two extra press/release pulses
    // mid-run; rst_at>0 asserts reset for one edge after cycle rst_at.
    task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                            input bit pulses, input int ncyc, input int rst_at, input string name);
        int          pa;
        int          pb;
        logic [15:0] exp_p;
        logic [10:0] ev;
        op_a = a;
        op_b = b;
        plan_ops(b);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CLK100MHZ);
            ev = (rst_at > 0 && c > rst_at) ? 11'd0 : exp_vec(c);
            check_eq($sformatf("%s_c%0d", name, c), 32'(obs_vec()), 32'(ev));
            if (!hold && c == 1) start = 1'b0;
            if (pulses && (c == 4 || c == 11)) start = 1'b1;
            if (pulses && (c == 5 || c == 12)) start = 1'b0;
            if (rst_at > 0 && c == rst_at) reset = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) reset = 1'b0;
        end
        if (rst_at == 0 && ncyc > 2 * N + 2) begin
            pa    = int'($signed(a));
            pb    = int'($signed(b));
            exp_p = 16'(pa * pb);
            check_eq($sformatf("%s_product", name), 32'(product), 32'(exp_p));
        end
    endtask

    task automatic idle_gap();
        start = 1'b0;
        @(negedge CLK100MHZ);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        // Reset held with the button pressed: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK100MHZ);
            check_eq($sformatf("reset_c%0d", i), 32'(obs_vec()), 32'd0);
        end
        reset = 1'b0;
        // Button still held after reset release: must not start.
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK100MHZ);
            check_eq($sformatf("held_after_reset_c%0d", i), 32'(obs_vec()), 32'd0);
        end

        idle_gap();
        run_mult(8'd7, 8'd4, 1'b0, 1'b0, 22, 0, "mul_7x4");
        idle_gap();
        run_mult(8'hFD, 8'd5, 1'b0, 1'b0, 22, 0, "mul_m3x5");

        // Held button: one result only, then a fresh press works.
        idle_gap();
        run_mult(8'd12, 8'hF6, 1'b1, 1'b0, 40, 0, "held_40");
        idle_gap();
        run_mult(8'h55, 8'hAA, 1'b0, 1'b0, 22, 0, "repress");

        // Extra presses while busy are ignored.
        idle_gap();
        run_mult(8'h7F, 8'h7F, 1'b0, 1'b1, 22, 0, "extra_pulses");

        // Reset during the third SHIFT (cycle 7) with the button held.
        idle_gap();
        run_mult(8'd9, 8'd9, 1'b1, 1'b0, 16, 7, "mid_reset");
        idle_gap();
        run_mult(8'd9, 8'd9, 1'b0, 1'b0, 22, 0, "after_reset");

        // Random operands; multiplicand -128 is outside what an N-bit
        // accumulator can represent for A-M, so it is re-rolled.
        for (int t = 0; t < 8; t++) begin
            ra = 8'($urandom);
            while (ra == 8'h80) ra = 8'($urandom);
            rb = 8'($urandom);
            idle_gap();
            run_mult(ra, rb, 1'b0, 1'b0, 21, 0, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
